// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared move encodings, FSM states and button decode for the RPS capture/judge path
package rps_pkg;

    localparam logic [1:0] MOVE_STONE    = 2'b00;
    localparam logic [1:0] MOVE_PAPER    = 2'b01;
    localparam logic [1:0] MOVE_SCISSORS = 2'b10;
    localparam logic [1:0] MOVE_NONE     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_REVEAL  = 2'b10,
        ST_DONE    = 2'b11
    } rps_state_t;

    // Anything other than a single pressed button decodes to "no move".
    function automatic logic [1:0] btn_to_move(input logic [2:0] btn);
        case (btn)
            3'b001:  return MOVE_STONE;
            3'b010:  return MOVE_PAPER;
            3'b100:  return MOVE_SCISSORS;
            default: return MOVE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rps_debounce.sv
// rtl/rps_debounce.sv - per-player button synchronizer, arming and one-hot debounce
module rps_debounce
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clear,
    input  logic       collect,
    input  logic [2:0] btn,
    output logic       press,
    output logic [1:0] move
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [2:0]    meta;
    logic [2:0]    sync;
    logic [2:0]    last;
    logic [CW-1:0] cnt;
    logic [CW-1:0] run;
    logic          armed;

    // Two-flop synchronizer on the raw buttons; frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 3'b000;
            sync <= 3'b000;
        end else if (ena) begin
            meta <= btn;
            sync <= meta;
        end
    end

    // Length of the current stable one-hot run including this cycle, saturating.
    always_comb begin
        run = '0;
        if (!$onehot(sync)) begin
            run = '0;
        end else if (sync != last) begin
            run = CW'(1);
        end else if (cnt == CNT_MAX) begin
            run = cnt;
        end else begin
            run = cnt + CW'(1);
        end
    end

    assign press = collect && armed && (run == CNT_MAX);
    assign move  = btn_to_move(sync);

    // Arming and run tracking, restarted whenever a new round is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            last  <= 3'b000;
            cnt   <= '0;
        end else if (ena) begin
            if (clear) begin
                armed <= 1'b0;
                last  <= 3'b000;
                cnt   <= '0;
            end else if (collect) begin
                if (sync == 3'b000) begin
                    armed <= 1'b1;
                end
                last <= sync;
                cnt  <= run;
            end
        end
    end

endmodule

// File: rtl/rps_move_capture.sv
// rtl/rps_move_capture.sv - two-player move capture with lock, timeout and one-cycle reveal strobe
module rps_move_capture
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       round_start,
    input  logic [2:0] p1_btn,
    input  logic [2:0] p2_btn,
    output logic [1:0] p1_move,
    output logic [1:0] p2_move,
    output logic       moves_valid,
    output logic       p1_locked,
    output logic       p2_locked,
    output logic       timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYCLES - 1);

    rps_state_t    state;
    rps_state_t    state_next;
    logic [TW-1:0] tcnt;
    logic          pending;
    logic          start_collect;
    logic          in_collect;
    logic          time_up;
    logic          p1_press;
    logic          p2_press;
    logic [1:0]    p1_code;
    logic [1:0]    p2_code;
    logic          p1_lock_now;
    logic          p2_lock_now;
    logic          both_locked;

    rps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_p1_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .clear   (start_collect),
        .collect (in_collect),
        .btn     (p1_btn),
        .press   (p1_press),
        .move    (p1_code)
    );

    rps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_p2_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .clear   (start_collect),
        .collect (in_collect),
        .btn     (p2_btn),
        .press   (p2_press),
        .move    (p2_code)
    );

    assign in_collect  = (state == ST_COLLECT);
    assign time_up     = (tcnt == TIME_LAST);
    assign p1_lock_now = in_collect && !round_start && p1_press && !p1_locked;
    assign p2_lock_now = in_collect && !round_start && p2_press && !p2_locked;
    assign both_locked = (p1_locked | p1_lock_now) & (p2_locked | p2_lock_now);

    // A fresh round begins on round_start, or from DONE when one arrived during REVEAL.
    always_comb begin
        start_collect = 1'b0;
        case (state)
            ST_IDLE, ST_COLLECT: start_collect = round_start;
            ST_DONE:             start_collect = round_start | pending;
            default:             start_collect = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Next-state logic; a restart inside COLLECT takes priority over reveal.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (round_start) state_next = ST_COLLECT;
            ST_COLLECT: if (!round_start && (both_locked || time_up)) state_next = ST_REVEAL;
            ST_REVEAL:  state_next = ST_DONE;
            ST_DONE:    if (start_collect) state_next = ST_COLLECT;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Reveal strobe is exactly the REVEAL state.
    always_comb begin
        moves_valid = 1'b0;
        if (state == ST_REVEAL) begin
            moves_valid = 1'b1;
        end
    end

    // Locked moves, timeout counter/flag and the deferred-restart flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_move   <= MOVE_NONE;
            p2_move   <= MOVE_NONE;
            p1_locked <= 1'b0;
            p2_locked <= 1'b0;
            timeout   <= 1'b0;
            tcnt      <= '0;
            pending   <= 1'b0;
        end else if (ena) begin
            if (start_collect) begin
                p1_move   <= MOVE_NONE;
                p2_move   <= MOVE_NONE;
                p1_locked <= 1'b0;
                p2_locked <= 1'b0;
                timeout   <= 1'b0;
                tcnt      <= '0;
                pending   <= 1'b0;
            end else begin
                if (p1_lock_now) begin
                    p1_move   <= p1_code;
                    p1_locked <= 1'b1;
                end
                if (p2_lock_now) begin
                    p2_move   <= p2_code;
                    p2_locked <= 1'b1;
                end
                if (in_collect && !both_locked) begin
                    if (time_up) begin
                        timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                if (state == ST_REVEAL && round_start) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/rps_move_capture.md
RPS_MOVE_CAPTURE -- requirements
Module: rps_move_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles required to accept a button press.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, meaning COLLECT cycles allowed before forced reveal.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  enable; when low, all state, counters and outputs hold.
REQ-006 round_start  input  1  single-cycle pulse that starts or restarts a round.
REQ-007 p1_btn  input  3  raw asynchronous buttons, bit0 stone, bit1 paper, bit2 scissors.
REQ-008 p2_btn  input  3  same as p1_btn, for player 2.
REQ-009 p1_move  output  2  locked move: 00 stone, 01 paper, 10 scissors, 11 none/invalid.
REQ-010 p2_move  output  2  same encoding, for player 2.
REQ-011 moves_valid  output  1  one-cycle strobe: both moves final.
REQ-012 p1_locked, p2_locked  output  1 each  player has committed a move this round.
REQ-013 timeout  output  1  round ended by timeout; held until next round_start.

Function
REQ-014 Each button bit SHALL pass a 2-flop synchronizer before any other use.
REQ-015 A player SHALL become armed once their synchronized vector is all-zero for at least 1 cycle after entry to COLLECT; unarmed players cannot lock.
REQ-016 An armed player's press SHALL be accepted when the synchronized vector is exactly one-hot and unchanged for DEBOUNCE_CYCLES consecutive cycles; a change, zero or multi-hot value clears the counter.
REQ-017 FSM states: IDLE, COLLECT, REVEAL, DONE.
REQ-018 IDLE -> COLLECT on round_start; COLLECT clears locks, arming, debounce and timeout counters and drives both moves to 11.
REQ-019 In COLLECT an accepted press SHALL register the move and set pX_locked on the next edge; later presses by that player are ignored.
REQ-020 COLLECT -> REVEAL on the edge both locks are set (including both in the same cycle); moves_valid SHALL be high exactly in the REVEAL cycle.
REQ-021 Timeout counter SHALL count COLLECT cycles; on reaching TIMEOUT_CYCLES-1 with a player unlocked, that player's move is 11, timeout sets, FSM enters REVEAL.
REQ-022 REVEAL -> DONE unconditionally after 1 cycle; DONE holds moves, locks and timeout stable.
REQ-023 round_start in COLLECT or DONE SHALL restart COLLECT on the next edge; round_start in REVEAL is deferred, taking effect from DONE one cycle later.
REQ-024 Lock and timeout in the same cycle: the lock wins, timeout stays 0.
REQ-025 Counters SHALL saturate, never wrap.

Reset
REQ-026 On rst_n low: state IDLE, p1_move/p2_move 11, moves_valid 0, locks 0, timeout 0, synchronizers and counters 0.
REQ-027 Reset mid-round SHALL abandon the round without emitting moves_valid.

Structure
REQ-028 Shared package rps_pkg SHALL hold the move encodings (MOVE_STONE, MOVE_PAPER, MOVE_SCISSORS, MOVE_NONE) and the FSM state enum; the downstream judge uses the same encodings.
REQ-029 Synchronizer plus debounce SHALL be a sub-module rps_debounce, instantiated once per player.

Verification (bench DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-030 round_start, p1_btn=001 for 6 cycles, then p2_btn=100 for 6 cycles -> single moves_valid pulse with p1_move=00, p2_move=10, timeout=0.
REQ-031 p1_btn=001 held from before round_start -> no lock until released to 000 and re-pressed for 4+ stable cycles.
REQ-032 p2_btn glitching 010/000 every 2 cycles, then 011 -> p2 never locks; after 64 COLLECT cycles moves_valid pulses with p2_move=11 and timeout=1.
REQ-033 Both players press valid one-hot buttons on the same cycle -> both locks set on the same edge; moves_valid follows 1 cycle later.
REQ-034 ena low for 20 cycles mid-debounce, then high -> counters resume from held values; no early lock, no timeout drift.
REQ-035 rst_n asserted while p1 is locked in COLLECT -> outputs return to reset values immediately, with no moves_valid pulse.
